bf16_dot_accum_44: RTL and testbench

- Downstream consumer of the 3-stage BF16 multiplier. Takes its product stream (result/valid) and accumulates products into a running BF16 sum for each vector.
- The vector boundary is the last_44 flag. The completed sum is presented on a valid/ready output register for the next block, such as an activation or writeback stage.
- Accepts one product per cycle with no input backpressure, matching the multiplier, which has no ready.

---
 rtl/bf16_pkg_44.sv | 19 +
 rtl/bf16_dot_accum_44_if.sv | 20 ++
 rtl/bf16_add_44.sv | 104 ++++++++++
 rtl/bf16_dot_accum_44.sv | 88 ++++++++
 tb/tb_bf16_dot_accum_44.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg_44.sv
// Shared BF16 field layout, special encodings and accumulator state codes
// for the BF16 dot-product accumulator.
package bf16_pkg_44;
   localparam int SIGN_B   = 15;
   localparam int EXP_MSB  = 14;
   localparam int EXP_LSB  = 7;
   localparam int MANT_MSB = 6;
   localparam int BIAS     = 127;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [15:0] QNAN    = 16'h7FC0;
   localparam logic [15:0] POS_INF = 16'h7F80;
   localparam logic [15:0] NEG_INF = 16'hFF80;
   localparam logic [15:0] ZERO    = 16'h0000;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;
endpackage

// File: rtl/bf16_dot_accum_44_if.sv
// Product input stream and completed-sum output register of the accumulator.
interface bf16_dot_accum_44_if #(parameter int CNT_W = 9);
   logic [15:0]      prod_44;
   logic             prod_valid_44;
   logic             last_44;
   logic [15:0]      sum_44;
   logic             sum_valid_44;
   logic             sum_ready_44;
   logic [CNT_W-1:0] sum_count_44;

   modport master (
      output prod_44, prod_valid_44, last_44, sum_ready_44,
      input  sum_44, sum_valid_44, sum_count_44
   );

   modport slave (
      input  prod_44, prod_valid_44, last_44, sum_ready_44,
      output sum_44, sum_valid_44, sum_count_44
   );
endinterface

// File: rtl/bf16_add_44.sv
// Combinational two-operand BF16 adder: subnormals as zero, RNE rounding,
// overflow to infinity, underflow flushed to signed zero.
module bf16_add_44
   import bf16_pkg_44::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   logic       sa, sb;
   logic [7:0] ea, eb;
   logic [6:0] ma, mb;
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign sa = a[SIGN_B];
   assign sb = b[SIGN_B];
   assign ea = a[EXP_MSB:EXP_LSB];
   assign eb = b[EXP_MSB:EXP_LSB];
   assign ma = a[MANT_MSB:0];
   assign mb = b[MANT_MSB:0];

   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == EXP_MAX) && (ma == 7'd0);
   assign b_inf  = (eb == EXP_MAX) && (mb == 7'd0);
   assign a_nan  = (ea == EXP_MAX) && (ma != 7'd0);
   assign b_nan  = (eb == EXP_MAX) && (mb != 7'd0);

   function automatic logic [3:0] lzc11(input logic [10:0] v);
      lzc11 = 4'd11;
      for (int i = 0; i < 11; i++) begin
         if (v[i]) lzc11 = 4'(10 - i);
      end
   endfunction

   function automatic logic rne_inc(input logic [10:0] v);
      // v[3] is the kept LSB, v[2:0] are guard/round/sticky
      rne_inc = v[2] & (v[1] | v[0] | v[3]);
   endfunction

   logic              swap;
   logic              s_big, s_sml;
   logic [7:0]        e_big, e_sml, d;
   logic [7:0]        sig_big, sig_sml;
   logic [18:0]       sh_tmp;
   logic [10:0]       big_ext, sml_ext, norm;
   logic [11:0]       raw;
   logic [3:0]        lz;
   logic signed [9:0] exp_n, exp_r;
   logic [8:0]        rnd;
   logic [6:0]        mant_r;

   assign swap    = {ea, ma} < {eb, mb};
   assign s_big   = swap ? sb : sa;
   assign s_sml   = swap ? sa : sb;
   assign e_big   = swap ? eb : ea;
   assign e_sml   = swap ? ea : eb;
   assign sig_big = {1'b1, swap ? mb : ma};
   assign sig_sml = {1'b1, swap ? ma : mb};
   assign d       = e_big - e_sml;

   always_comb begin
      big_ext = {sig_big, 3'b000};
      sh_tmp  = {sig_sml, 11'b0} >> d;
      // Anything shifted past the guard/round bits folds into sticky
      if (d >= 8'd11) sml_ext = 11'd1;
      else            sml_ext = sh_tmp[18:8] | {10'b0, |sh_tmp[7:0]};

      if (s_big == s_sml) raw = {1'b0, big_ext} + {1'b0, sml_ext};
      else                raw = {1'b0, big_ext} - {1'b0, sml_ext};

      lz = 4'd0;
      if (raw[11]) begin
         norm  = raw[11:1] | {10'b0, raw[0]};
         exp_n = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         lz    = lzc11(raw[10:0]);
         norm  = raw[10:0] << lz;
         exp_n = $signed({2'b00, e_big}) - $signed({6'b0, lz});
      end

      rnd = {1'b0, norm[10:3]} + {8'b0, rne_inc(norm)};
      if (rnd[8]) begin
         mant_r = rnd[7:1];
         exp_r  = exp_n + 10'sd1;
      end else begin
         mant_r = rnd[6:0];
         exp_r  = exp_n;
      end

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y = QNAN;
      else if (a_inf)                                       y = a;
      else if (b_inf)                                       y = b;
      else if (a_zero && b_zero)                            y = {sa & sb, 15'b0};
      else if (a_zero)                                      y = b;
      else if (b_zero)                                      y = a;
      else if (raw == 12'd0)                                y = ZERO;
      else if (exp_r >= 10'sd255)                           y = s_big ? NEG_INF : POS_INF;
      else if (exp_r <= 10'sd0)                             y = {s_big, 15'b0};
      else                                                  y = {s_big, exp_r[7:0], mant_r};
   end

endmodule

// File: rtl/bf16_dot_accum_44.sv
// Accumulates a BF16 product stream into per-vector sums delimited by last_44,
// presenting each sum on a valid/ready output register.
module bf16_dot_accum_44
   import bf16_pkg_44::*;
#(
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = 9
) (
   input  logic clk_44,
   input  logic rst_n_44,
   bf16_dot_accum_44_if.slave bus,
   output logic busy_44,
   output logic err_overlen_44,
   output logic err_overrun_44
);

   localparam logic [0:0]       S_IDLE  = IDLE;
   localparam logic [0:0]       S_ACCUM = ACCUM;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       state_p0, state_nxt;
   logic [15:0]      acc_p0, acc_nxt, add_y;
   logic [CNT_W-1:0] cnt_p0, cnt_nxt;
   logic [15:0]      sum_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             vld_p1;
   logic             complete, overlen_hit;

   bf16_add_44 u_add (
      .a (acc_p0),
      .b (bus.prod_44),
      .y (add_y)
   );

   always_comb begin
      state_nxt   = state_p0;
      acc_nxt     = acc_p0;
      cnt_nxt     = cnt_p0;
      complete    = 1'b0;
      overlen_hit = 1'b0;
      if (bus.prod_valid_44) begin
         if (state_p0 == S_IDLE) begin
            acc_nxt = bus.prod_44;
            cnt_nxt = CNT_ONE;
         end else begin
            acc_nxt = add_y;
            if (cnt_p0 == CNT_MAX) overlen_hit = 1'b1;
            else                   cnt_nxt     = cnt_p0 + CNT_ONE;
         end
         complete  = bus.last_44;
         state_nxt = bus.last_44 ? S_IDLE : S_ACCUM;
      end
   end

   // Stage p0: accumulator / FSM; stage p1: completed-sum output register
   always_ff @(posedge clk_44 or negedge rst_n_44) begin
      if (!rst_n_44) begin
         state_p0       <= S_IDLE;
         acc_p0         <= ZERO;
         cnt_p0         <= '0;
         sum_p1         <= ZERO;
         cnt_p1         <= '0;
         vld_p1         <= 1'b0;
         err_overlen_44 <= 1'b0;
         err_overrun_44 <= 1'b0;
      end else begin
         state_p0 <= state_nxt;
         acc_p0   <= acc_nxt;
         cnt_p0   <= cnt_nxt;
         if (overlen_hit) err_overlen_44 <= 1'b1;
         if (complete) begin
            sum_p1 <= acc_nxt;
            cnt_p1 <= cnt_nxt;
            vld_p1 <= 1'b1;
            if (vld_p1 && !bus.sum_ready_44) err_overrun_44 <= 1'b1;
         end else if (vld_p1 && bus.sum_ready_44) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.sum_44       = sum_p1;
   assign bus.sum_count_44 = cnt_p1;
   assign bus.sum_valid_44 = vld_p1;
   assign busy_44          = (state_p0 == S_ACCUM);

endmodule

// File: tb/tb_bf16_dot_accum_44.sv
// Directed bench for bf16_dot_accum_44: two-term vector table plus hand
// sequences for multi-term sums, back-to-back overrun, over-length and reset.
module tb_bf16_dot_accum_44;

   logic clk_44;
   logic rst_n_44;
   logic busy_44, err_overlen_44, err_overrun_44;
   int   total = 0;
   int   bad   = 0;

   bf16_dot_accum_44_if #(.CNT_W(9)) bus ();

   bf16_dot_accum_44 #(.MAX_LEN(4), .CNT_W(9)) dut (
      .clk_44         (clk_44),
      .rst_n_44       (rst_n_44),
      .bus            (bus.slave),
      .busy_44        (busy_44),
      .err_overlen_44 (err_overlen_44),
      .err_overrun_44 (err_overrun_44)
   );

   initial clk_44 = 1'b0;
   always #5 clk_44 = ~clk_44;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] s;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_44);
      #1;
   endtask

   task automatic send(input logic [15:0] p, input logic last);
      bus.prod_44       = p;
      bus.prod_valid_44 = 1'b1;
      bus.last_44       = last;
      step();
   endtask

   task automatic idle();
      bus.prod_valid_44 = 1'b0;
      bus.last_44       = 1'b0;
      step();
   endtask

   initial begin
      tbl[0]  = '{16'h4380, 16'h3F80, 16'h4380};  // 256+1 tie -> even
      tbl[1]  = '{16'h4380, 16'h4000, 16'h4381};  // 256+2
      tbl[2]  = '{16'h4381, 16'h3F80, 16'h4382};  // 258+1 tie -> rounds up to even
      tbl[3]  = '{16'h7F80, 16'hFF80, 16'h7FC0};  // inf - inf
      tbl[4]  = '{16'h7F7F, 16'h7F7F, 16'h7F80};  // overflow
      tbl[5]  = '{16'h3F80, 16'hBF80, 16'h0000};  // exact cancel
      tbl[6]  = '{16'h7FC1, 16'h3F80, 16'h7FC0};  // NaN operand
      tbl[7]  = '{16'hFF80, 16'h4000, 16'hFF80};  // -inf + finite
      tbl[8]  = '{16'h8000, 16'h8000, 16'h8000};  // -0 + -0
      tbl[9]  = '{16'h0001, 16'h3F80, 16'h3F80};  // subnormal as zero
      tbl[10] = '{16'h3F80, 16'hBF00, 16'h3F00};  // 1 - 0.5
      tbl[11] = '{16'h0100, 16'h80C0, 16'h0000};  // underflow flush

      rst_n_44          = 1'b0;
      bus.prod_44       = 16'h0;
      bus.prod_valid_44 = 1'b0;
      bus.last_44       = 1'b0;
      bus.sum_ready_44  = 1'b1;
      step();
      step();
      check("rst_sum_valid", 32'(bus.sum_valid_44), 32'd0);
      check("rst_sum",       32'(bus.sum_44),       32'h0);
      check("rst_count",     32'(bus.sum_count_44), 32'd0);
      check("rst_busy",      32'(busy_44),          32'd0);
      check("rst_errs",      32'({err_overlen_44, err_overrun_44}), 32'd0);
      rst_n_44 = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         send(tbl[i].a, 1'b0);
         check($sformatf("v%0d_busy", i), 32'(busy_44), 32'd1);
         send(tbl[i].b, 1'b1);
         check($sformatf("v%0d_sum", i),   32'(bus.sum_44),       32'(tbl[i].s));
         check($sformatf("v%0d_count", i), 32'(bus.sum_count_44), 32'd2);
         check($sformatf("v%0d_valid", i), 32'(bus.sum_valid_44), 32'd1);
         idle();
         check($sformatf("v%0d_drain", i), 32'({bus.sum_valid_44, busy_44}), 32'd0);
      end

      // Three-term vector, sum visible the cycle after last
      send(16'h3F80, 1'b0);
      send(16'h4000, 1'b0);
      check("three_early_valid", 32'(bus.sum_valid_44), 32'd0);
      send(16'h3F00, 1'b1);
      check("three_sum",   32'(bus.sum_44),       32'h4060);
      check("three_count", 32'(bus.sum_count_44), 32'd3);
      idle();

      // Single-term vector completes straight from IDLE
      send(16'hC0A0, 1'b1);
      check("single_sum",   32'(bus.sum_44),       32'hC0A0);
      check("single_count", 32'(bus.sum_count_44), 32'd1);
      check("single_busy",  32'(busy_44),          32'd0);
      idle();

      // Back-to-back vectors with downstream stalled
      check("pre_overrun", 32'(err_overrun_44), 32'd0);
      bus.sum_ready_44 = 1'b0;
      send(16'h3F80, 1'b0);
      send(16'h3F80, 1'b1);
      check("bb_a_sum",     32'(bus.sum_44),       32'h4000);
      check("bb_a_count",   32'(bus.sum_count_44), 32'd2);
      check("bb_a_overrun", 32'(err_overrun_44),   32'd0);
      send(16'h4040, 1'b1);
      check("bb_b_sum",     32'(bus.sum_44),       32'h4040);
      check("bb_b_count",   32'(bus.sum_count_44), 32'd1);
      check("bb_b_overrun", 32'(err_overrun_44),   32'd1);
      check("bb_b_valid",   32'(bus.sum_valid_44), 32'd1);
      idle();
      check("bb_hold_valid", 32'(bus.sum_valid_44), 32'd1);
      bus.sum_ready_44 = 1'b1;
      idle();
      check("bb_accept", 32'(bus.sum_valid_44), 32'd0);
      check("bb_sticky", 32'(err_overrun_44),   32'd1);

      // Completion coinciding with acceptance is not an overrun (after reset)
      rst_n_44 = 1'b0;
      #1;
      rst_n_44 = 1'b1;
      send(16'h3F80, 1'b1);
      send(16'h4000, 1'b1);
      check("accept_sum",     32'(bus.sum_44),     32'h4000);
      check("accept_overrun", 32'(err_overrun_44), 32'd0);
      idle();

      // Over-length with MAX_LEN=4
      for (int k = 0; k < 4; k++) send(16'h3F80, 1'b0);
      check("ol_before", 32'(err_overlen_44), 32'd0);
      send(16'h3F80, 1'b1);
      check("ol_flag",  32'(err_overlen_44),   32'd1);
      check("ol_sum",   32'(bus.sum_44),       32'h40A0);
      check("ol_count", 32'(bus.sum_count_44), 32'd4);

      // Reset in the middle of a vector
      send(16'h4000, 1'b0);
      send(16'h4000, 1'b0);
      check("mid_busy", 32'(busy_44), 32'd1);
      #2;
      rst_n_44 = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy_44),          32'd0);
      check("mid_rst_sum",   32'(bus.sum_44),       32'h0);
      check("mid_rst_count", 32'(bus.sum_count_44), 32'd0);
      check("mid_rst_errs",  32'({err_overlen_44, err_overrun_44}), 32'd0);
      bus.prod_valid_44 = 1'b0;
      step();
      rst_n_44 = 1'b1;
      send(16'h4000, 1'b1);
      check("post_rst_sum",   32'(bus.sum_44),       32'h4000);
      check("post_rst_count", 32'(bus.sum_count_44), 32'd1);
      check("post_rst_valid", 32'(bus.sum_valid_44), 32'd1);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
